run_tracker: RTL and testbench
==============================

# run_tracker

Downstream consumer of the one-hot sequence detector's `z` output. It measures each contiguous run of `z` = 1, in clock cycles, and counts completed runs. It also keeps the longest run seen and reports each finished run with a one-cycle pulse. It sits between the detector and the board display/LED logic, on the detector's clock.

## Interface
- `LEN_W`, default 8: width of run-length registers; lengths saturate at 2^LEN_W−1.
- `CNT_W`, default 8: width of the completed-run counter; wraps, with a sticky overflow flag.

- `clk` input 1: system clock, rising edge; same clock as the detector.
- `reset_n` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `z` input 1: detector output; 1 while the detector is in its "two or more consecutive 1s" state.
- `clear` input 1: synchronous statistics clear.
- `run_done` output 1: one-cycle pulse; a run has just ended.
- `last_len` output LEN_W: length of the most recently completed run.
- `cur_len` output LEN_W: length of the run in progress; 0 when no run is active.
- `max_len` output LEN_W: longest completed run since reset or clear.
- `run_count` output CNT_W: number of completed runs, modulo 2^CNT_W.
- `ovf` output 1: sticky flag; `run_count` has wrapped.

## Operation
- All outputs are registered. Reset (`reset_n` = 0 at an edge) forces:
  - state = IDLE;
  - `run_done` = 0, `last_len` = 0, `cur_len` = 0, `max_len` = 0, `run_count` = 0, `ovf` = 0.
- FSM, one-hot encoded with three states: IDLE, RUN, DONE.
- IDLE:
  - `z` = 1 → RUN, `cur_len` ← 1.
  - `z` = 0 → stay in IDLE.
- RUN:
  - `z` = 1 → stay in RUN, `cur_len` ← `cur_len` + 1, saturating at all-ones.
  - `z` = 0 → DONE, and at the same edge:
    - `last_len` ← `cur_len`;
    - `max_len` ← max(`max_len`, `cur_len`), unsigned compare; ties leave it unchanged;
    - `run_count` ← `run_count` + 1; if the old value was all-ones it wraps to 0 and `ovf` ← 1;
    - `run_done` ← 1;
    - `cur_len` ← 0.
- DONE (lasts one cycle; `run_done` = 1 during it):
  - `z` = 1 → RUN, `cur_len` ← 1, `run_done` ← 0. Back-to-back runs separated by a single 0 are both counted.
  - `z` = 0 → IDLE, `run_done` ← 0.
- `clear` = 1 at an edge (with `reset_n` = 1):
  - zeroes `last_len`, `max_len`, `run_count` and `ovf`;
  - FSM state, `cur_len` and `run_done` are unaffected;
  - if a run ends on the same edge, `run_done` still pulses, but the statistics registers take the cleared values (clear wins).
- `reset_n` has priority over `clear` and over all FSM activity.
- A reset in the middle of a run discards that run; it is not counted.
- Length meaning: a `z` run of length N corresponds to N+1 consecutive 1s on the detector's `w` input.

## Timing
- `z` is sampled on every rising edge of `clk`; there is no input synchronizer, because `z` comes from the same clock domain.
- Run end is detected on the first edge with `z` = 0. `run_done`, `last_len`, `max_len` and `run_count` update at that edge, so they are visible one cycle after the last `z` = 1 cycle.
- `cur_len` equals the number of `z` = 1 edges sampled so far in the current run.
- Minimum spacing between `run_done` pulses: 2 cycles (run of length 1, one 0, run of length 1).
- A saturated `cur_len` stays at all-ones until the run ends, and the reported `last_len` is all-ones.

## Structure
- Shared package `run_tracker_pkg`:
  - state index constants S_IDLE, S_RUN, S_DONE (bit positions of the one-hot vector);
  - default widths.
- One natural sub-module: `sat_inc`, a parameterised saturating incrementer (width parameter, value in, value + 1 out, clamped at all-ones). It is used for `cur_len`.
- State flops hold the one-hot vector. Reset loads IDLE = 1 and all others 0. Next-state logic is written as per-state sum-of-products equations.

## Test plan
- Reset then hold: drive `reset_n` = 0 for 2 cycles, then hold `z` = 0 for 5 cycles → all outputs 0, state IDLE, no `run_done`.
- Single run: drive `z` = 1 for 3 cycles, then 0 → one `run_done` pulse on the cycle after the last 1; `last_len` = 3, `max_len` = 3, `run_count` = 1; `cur_len` reads 1, 2, 3, then 0.
- Back-to-back runs: `z` pattern 1,1,0,1,0,0 → two `run_done` pulses, 2 cycles apart; `last_len` = 2 then 1; `max_len` = 2; `run_count` = 2.
- Saturation and wrap with `LEN_W` = 3, `CNT_W` = 2:
  - a 10-cycle run → `cur_len` holds 7 and `last_len` = 7;
  - five 1-cycle runs → `run_count` = 1 and `ovf` = 1.
- Clear coincident with run end: `z` = 1,1,0 with `clear` = 1 on the ending edge → `run_done` pulses; `last_len` = 0, `max_len` = 0, `run_count` = 0.
- Reset mid-run: `z` = 1 for 4 cycles, then `reset_n` = 0 for 1 cycle with `z` still 1 → all outputs 0. Releasing reset with `z` = 1 starts a new run at `cur_len` = 1; `run_count` stays 0 until that run ends.

Source files
------------

// File: rtl/run_tracker_pkg.sv
// rtl/run_tracker_pkg.sv - shared constants for the run_tracker block
package run_tracker_pkg;

  // Bit positions inside the one-hot state vector
  localparam int S_IDLE     = 0;
  localparam int S_RUN      = 1;
  localparam int S_DONE     = 2;
  localparam int NUM_STATES = 3;

  // One-hot vector loaded at reset
  localparam logic [NUM_STATES-1:0] IDLE_VEC = 3'b001;

  // Default register widths
  localparam int LEN_W_DEF = 8;
  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/run_tracker_sat_inc.sv
// rtl/run_tracker_sat_inc.sv - saturating incrementer, clamps at all-ones
module sat_inc #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  // Hold at all-ones instead of wrapping back to zero
  assign y = (&a) ? a : a + W'(1);

endmodule

// File: rtl/run_tracker.sv
// rtl/run_tracker.sv - measures and counts runs of the detector's z output
module run_tracker
  import run_tracker_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             z,
  input  logic             clear,
  output logic             run_done,
  output logic [LEN_W-1:0] last_len,
  output logic [LEN_W-1:0] cur_len,
  output logic [LEN_W-1:0] max_len,
  output logic [CNT_W-1:0] run_count,
  output logic             ovf
);

  logic [NUM_STATES-1:0] state;
  logic [NUM_STATES-1:0] state_nxt;

  logic [LEN_W-1:0] cur_inc;
  logic [LEN_W-1:0] cur_nxt;
  logic [LEN_W-1:0] last_nxt;
  logic [LEN_W-1:0] max_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_nxt;
  logic             done_nxt;
  logic             run_end;
  logic             run_start;

  sat_inc #(.W(LEN_W)) u_cur_inc (
    .a (cur_len),
    .y (cur_inc)
  );

  // State and all output registers; reset overrides everything
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE_VEC;
      run_done  <= 1'b0;
      last_len  <= '0;
      cur_len   <= '0;
      max_len   <= '0;
      run_count <= '0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_nxt;
      run_done  <= done_nxt;
      last_len  <= last_nxt;
      cur_len   <= cur_nxt;
      max_len   <= max_nxt;
      run_count <= cnt_nxt;
      ovf       <= ovf_nxt;
    end
  end

  // Next-state sum-of-products; an all-zero vector falls back to IDLE
  always_comb begin
    state_nxt         = '0;
    state_nxt[S_IDLE] = (state[S_IDLE] & ~z) | (state[S_DONE] & ~z) | ~(|state);
    state_nxt[S_RUN]  = (state[S_IDLE] &  z) | (state[S_RUN]  &  z) | (state[S_DONE] & z);
    state_nxt[S_DONE] = state[S_RUN] & ~z;
  end

  // Next values of the registered outputs; clear only touches the statistics
  always_comb begin
    run_end   = state[S_RUN] & ~z;
    run_start = z & (state[S_IDLE] | state[S_DONE]);
    done_nxt  = run_end;

    cur_nxt = '0;
    if (state[S_RUN] && z) begin
      cur_nxt = cur_inc;
    end else if (run_start) begin
      cur_nxt = LEN_W'(1);
    end

    last_nxt = last_len;
    max_nxt  = max_len;
    cnt_nxt  = run_count;
    ovf_nxt  = ovf;
    if (run_end) begin
      last_nxt = cur_len;
      if (cur_len > max_len) begin
        max_nxt = cur_len;
      end
      cnt_nxt = run_count + CNT_W'(1);
      if (&run_count) begin
        ovf_nxt = 1'b1;
      end
    end

    if (clear) begin
      last_nxt = '0;
      max_nxt  = '0;
      cnt_nxt  = '0;
      ovf_nxt  = 1'b0;
    end
  end

endmodule

// File: tb/tb_run_tracker.sv
// tb/tb_run_tracker.sv - self-checking bench for run_tracker at two widths
module tb_run_tracker;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic z = 1'b0;
  logic clear = 1'b0;

  // Instance 0: default widths; instance 1: LEN_W=3, CNT_W=2
  logic       rd_a, ovf_a;
  logic [7:0] last_a, cur_a, max_a, cnt_a;
  logic       rd_b, ovf_b;
  logic [2:0] last_b, cur_b, max_b;
  logic [1:0] cnt_b;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state per instance: plain integers describing the current run
  int lmax [2] = '{255, 7};
  int cmod [2] = '{256, 4};
  bit m_run  [2];
  int m_cur  [2];
  int m_last [2];
  int m_max  [2];
  int m_cnt  [2];
  bit m_ovf  [2];
  bit m_done [2];

  always #5 clk = ~clk;

  run_tracker dut_a (
    .clk (clk), .reset_n (reset_n), .z (z), .clear (clear),
    .run_done (rd_a), .last_len (last_a), .cur_len (cur_a),
    .max_len (max_a), .run_count (cnt_a), .ovf (ovf_a)
  );

  run_tracker #(.LEN_W(3), .CNT_W(2)) dut_b (
    .clk (clk), .reset_n (reset_n), .z (z), .clear (clear),
    .run_done (rd_b), .last_len (last_b), .cur_len (cur_b),
    .max_len (max_b), .run_count (cnt_b), .ovf (ovf_b)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: a run is a stretch of z=1 edges; it ends on the first z=0 edge
  task automatic model_tick(input bit zi, input bit ci, input bit ri);
    for (int i = 0; i < 2; i++) begin
      if (!ri) begin
        m_run[i] = 0; m_cur[i] = 0; m_last[i] = 0; m_max[i] = 0;
        m_cnt[i] = 0; m_ovf[i] = 0; m_done[i] = 0;
      end else begin
        m_done[i] = m_run[i] && !zi;
        if (m_done[i]) begin
          m_last[i] = m_cur[i];
          if (m_cur[i] > m_max[i]) m_max[i] = m_cur[i];
          if (m_cnt[i] + 1 == cmod[i]) begin
            m_cnt[i] = 0;
            m_ovf[i] = 1;
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
        if (zi) m_cur[i] = m_run[i] ? ((m_cur[i] + 1 > lmax[i]) ? lmax[i] : m_cur[i] + 1) : 1;
        else    m_cur[i] = 0;
        m_run[i] = zi;
        if (ci) begin
          m_last[i] = 0; m_max[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
        end
      end
    end
  endtask

  // Drive on the falling edge, advance the model on the rising edge
  task automatic step(input bit zi, input bit ci = 1'b0, input bit ri = 1'b1);
    @(negedge clk);
    z = zi;
    clear = ci;
    reset_n = ri;
    @(posedge clk);
    model_tick(zi, ci, ri);
    #1;
  endtask

  // Every cycle: both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("a.run_done",  int'(rd_a),   int'(m_done[0]));
      check("a.last_len",  int'(last_a), m_last[0]);
      check("a.cur_len",   int'(cur_a),  m_cur[0]);
      check("a.max_len",   int'(max_a),  m_max[0]);
      check("a.run_count", int'(cnt_a),  m_cnt[0]);
      check("a.ovf",       int'(ovf_a),  int'(m_ovf[0]));
      check("b.run_done",  int'(rd_b),   int'(m_done[1]));
      check("b.last_len",  int'(last_b), m_last[1]);
      check("b.cur_len",   int'(cur_b),  m_cur[1]);
      check("b.max_len",   int'(max_b),  m_max[1]);
      check("b.run_count", int'(cnt_b),  m_cnt[1]);
      check("b.ovf",       int'(ovf_b),  int'(m_ovf[1]));
    end
  end

  initial begin
    // Reset then hold z low
    step(0, 0, 0);
    chk_en = 1'b1;
    step(0, 0, 0);
    repeat (5) step(0);
    check("lit.reset_state", int'(dut_a.state), 1);
    check("lit.reset_cnt", int'(cnt_a), 0);
    check("lit.reset_done", int'(rd_a), 0);

    // Single run of 3
    step(1); check("lit.single_cur1", int'(cur_a), 1);
    step(1); check("lit.single_cur2", int'(cur_a), 2);
    step(1); check("lit.single_cur3", int'(cur_a), 3);
    step(0);
    check("lit.single_done", int'(rd_a), 1);
    check("lit.single_cur0", int'(cur_a), 0);
    check("lit.single_last", int'(last_a), 3);
    check("lit.single_max", int'(max_a), 3);
    check("lit.single_cnt", int'(cnt_a), 1);
    step(0); check("lit.single_pulse_end", int'(rd_a), 0);

    // Back-to-back runs 1,1,0,1,0,0
    step(0, 0, 0);
    step(1); step(1); step(0);
    check("lit.b2b_done1", int'(rd_a), 1);
    check("lit.b2b_last1", int'(last_a), 2);
    step(1);
    check("lit.b2b_gap", int'(rd_a), 0);
    step(0);
    check("lit.b2b_done2", int'(rd_a), 1);
    check("lit.b2b_last2", int'(last_a), 1);
    check("lit.b2b_max", int'(max_a), 2);
    check("lit.b2b_cnt", int'(cnt_a), 2);
    step(0);

    // Saturation: 10-cycle run
    step(0, 0, 0);
    repeat (10) step(1);
    check("lit.sat_cur_b", int'(cur_b), 7);
    check("lit.sat_cur_a", int'(cur_a), 10);
    step(0);
    check("lit.sat_last_b", int'(last_b), 7);
    check("lit.sat_last_a", int'(last_a), 10);

    // Wrap: five 1-cycle runs
    step(0, 0, 0);
    repeat (5) begin step(1); step(0); end
    check("lit.wrap_cnt_b", int'(cnt_b), 1);
    check("lit.wrap_ovf_b", int'(ovf_b), 1);
    check("lit.wrap_cnt_a", int'(cnt_a), 5);
    check("lit.wrap_ovf_a", int'(ovf_a), 0);

    // Clear on the run-ending edge
    step(1); step(1); step(0, 1);
    check("lit.clr_done", int'(rd_a), 1);
    check("lit.clr_last", int'(last_a), 0);
    check("lit.clr_max", int'(max_a), 0);
    check("lit.clr_cnt", int'(cnt_a), 0);
    check("lit.clr_ovf_b", int'(ovf_b), 0);
    step(0);

    // Reset mid-run discards the run
    repeat (4) step(1);
    step(1, 0, 0);
    check("lit.midrst_cur", int'(cur_a), 0);
    check("lit.midrst_cnt", int'(cnt_a), 0);
    step(1);
    check("lit.midrst_newrun", int'(cur_a), 1);
    check("lit.midrst_cnt_hold", int'(cnt_a), 0);
    step(0);
    check("lit.midrst_cnt_end", int'(cnt_a), 1);

    // Mixed traffic with occasional clears, model-checked every cycle
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 9) < 6), ($urandom_range(0, 49) == 0));
    end
    step(0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
